branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Parametrised branch target buffer (BTB) with per-entry saturating direction counters for the 5-stage pipeline CPU.
//  - Replaces the static predict-not-taken scheme: the IF stage looks up PC_now and receives a predicted next PC in the same cycle.
//  - The EX stage reports each resolved branch/jump. The block updates its table and signals mispredict plus the redirect PC.
//  - The pipeline uses mispredict/redirect_pc to drive the IF/ID and ID/EX flush and the PC mux.
// PARAMETERS
//  ENTRIES  16  number of BTB entries; power of 2, 2..256; IDX_W = log2(ENTRIES)
//  TAG_W    8   tag bits stored per entry, taken from pc[IDX_W+TAG_W+1 : IDX_W+2]
//  CNT_W    2   direction counter width; taken when counter MSB = 1
// PORTS
//  clk             in   1   system clock, rising edge
//  reset           in   1   asynchronous, active-high; clears the whole table
//  lookup_pc       in   32  IF-stage PC (PC_now)
//  pred_taken      out  1   lookup hit AND counter MSB = 1 (combinational)
//  pred_target     out  32  stored target if pred_taken, else lookup_pc+4
//  upd_valid       in   1   EX holds a resolved branch/jump this cycle
//  upd_pc          in   32  PC of the resolved instruction (EXPC)
//  upd_taken       in   1   actual outcome
//  upd_target      in   32  actual taken target
//  upd_pred_taken  in   1   pred_taken carried down the pipeline with the instruction
//  upd_pred_target in   32  pred_target carried down the pipeline with the instruction
//  clear           in   1   synchronous invalidate-all (e.g. after instruction memory reload)
//  mispredict      out  1   combinational; upd_valid AND the prediction was wrong
//  redirect_pc     out  32  upd_target if upd_taken, else upd_pc+4
//  stat_branches   out  32  resolved-branch counter (see CONFIGURATION)
//  stat_mispred    out  32  mispredict counter (see CONFIGURATION)
// BEHAVIOUR
//  - Entry: {valid, tag[TAG_W], target[32], cnt[CNT_W]}.
//  - Index: pc[IDX_W+1:2]. Hit: valid AND the stored tag equals the PC tag field. Bits pc[1:0] are ignored.
//  - Lookup is purely combinational, 0-cycle latency; it reads pre-edge table state.
//  - A same-cycle update to the same index does not forward to the lookup; the new value is visible from the next cycle.
//  - mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_target != upd_pred_target)).
//  - redirect_pc is valid only while mispredict = 1; it may hold any value otherwise.
//  - Table update on the rising edge when upd_valid = 1:
//    * hit, taken: cnt = min(cnt+1, 2^CNT_W-1); target = upd_target
//    * hit, not taken: cnt = max(cnt-1, 0); target unchanged
//    * miss, taken: allocate and overwrite the entry; valid = 1, new tag, target = upd_target, cnt = 2^(CNT_W-1) (weakly taken)
//    * miss, not taken: no change (no allocation)
//  - clear = 1: all valid bits go to 0 on the edge.
//  - clear and upd_valid in the same cycle: clear wins; the update is dropped.
//  - Reset (async, any time, including mid-update): all valid = 0; cnt = 2^(CNT_W-1)-1 (weakly not-taken); tag/target = 0.
//  - Reset output values: pred_taken = 0, pred_target = lookup_pc+4, mispredict follows its inputs (combinational), stats = 0.
//  - Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFFFFFC + 4 = 0). Counters saturate and never wrap.
//  - Pipeline integration rules (the block does not enforce these):
//    * The pipeline gates upd_valid to 0 for flushed/bubble instructions.
//    * A held IF stage (stall) simply re-presents the same lookup_pc; the result is identical.
// CONFIGURATION
//  BP_STATS_EN defined:
//  - stat_branches increments on every upd_valid edge not suppressed by clear.
//  - stat_mispred increments when the same condition holds AND mispredict = 1.
//  - Both are 32-bit counters, saturating at 32'hFFFFFFFF, reset to 0; clear does not reset them.
//  BP_STATS_EN undefined:
//  - No counter flops; both stat ports are tied to 32'h0; all ports remain present.
// TESTING
//  - Reset, then lookup_pc=0x00400010 -> pred_taken=0, pred_target=0x00400014, stats=0.
//  - Update pc=0x00400010 taken, target 0x00400100, pred_taken=0 -> mispredict=1, redirect=0x00400100;
//    next-cycle lookup -> pred_taken=1, pred_target=0x00400100.
//  - Same pc resolved not-taken twice with correct preds carried -> cnt 10->01->00; lookup pred_taken=0.
//    One more not-taken leaves cnt=00 (saturation). Four taken -> cnt=11, not above.
//  - Aliasing: ENTRIES=16, train 0x00400010 taken, then update 0x00400050 (same index, different tag) taken
//    -> entry replaced; lookup 0x00400010 misses, pred_target=0x00400014.
//  - Same-cycle lookup and update of one index -> lookup returns old value; clear with upd_valid -> all lookups miss,
//    stat_branches unchanged.
//  - BP_STATS_EN: 10 updates, 3 mispredicted -> stat_branches=10, stat_mispred=3;
//    async reset asserted mid-sequence -> both 0 and table empty immediately.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters; 0-cycle lookup, EX-stage update.
// Optional statistics counters are built when BP_STATS_EN is defined.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] lookup_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  input  logic        clear,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispred
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W-1));
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W-1)) - 1);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [CNT_W-1:0] cnt;
  } entry_t;

  entry_t btb [ENTRIES];

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, u_hit;

  assign l_idx = lookup_pc[IDX_W+1:2];
  assign l_tag = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  assign l_hit = btb[l_idx].valid && (btb[l_idx].tag == l_tag);
  assign u_hit = btb[u_idx].valid && (btb[u_idx].tag == u_tag);

  // Lookup reads pre-edge state; same-cycle updates are not forwarded.
  assign pred_taken  = l_hit && btb[l_idx].cnt[CNT_W-1];
  assign pred_target = pred_taken ? btb[l_idx].target : lookup_pc + 32'd4;

  assign mispredict  = upd_valid &&
                       ((upd_taken != upd_pred_taken) ||
                        (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++)
        btb[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_WNT};
    end else if (clear) begin
      for (int i = 0; i < ENTRIES; i++)
        btb[i].valid <= 1'b0;
    end else if (upd_valid) begin
      if (u_hit) begin
        if (upd_taken) begin
          btb[u_idx].target <= upd_target;
          if (btb[u_idx].cnt != CNT_MAX) btb[u_idx].cnt <= btb[u_idx].cnt + CNT_ONE;
        end else if (btb[u_idx].cnt != '0) begin
          btb[u_idx].cnt <= btb[u_idx].cnt - CNT_ONE;
        end
      end else if (upd_taken) begin
        // Miss on a taken branch replaces whatever aliased into this slot.
        btb[u_idx] <= '{valid: 1'b1, tag: u_tag, target: upd_target, cnt: CNT_WT};
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] branches_q, mispred_q;
  logic        cnt_en;

  assign cnt_en = upd_valid && !clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branches_q <= '0;
      mispred_q  <= '0;
    end else if (cnt_en) begin
      if (branches_q != 32'hFFFF_FFFF) branches_q <= branches_q + 32'd1;
      if (mispredict && mispred_q != 32'hFFFF_FFFF) mispred_q <= mispred_q + 32'd1;
    end
  end

  assign stat_branches = branches_q;
  assign stat_mispred  = mispred_q;
`else
  assign stat_branches = 32'h0;
  assign stat_mispred  = 32'h0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus queues expected outputs, a negedge monitor compares.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        clear;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  branch_predictor dut (
    .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .clear(clear),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  always #5 clk = ~clk;

`ifdef BP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_b = 0;
  int   exp_m = 0;

  // Monitor: everything queued this cycle is compared at the falling edge.
  always @(negedge clk) begin
    chk_t        c;
    logic [31:0] act;
    while (sbq.size() > 0) begin
      c = sbq.pop_front();
      case (c.sel)
        0:       act = {31'b0, pred_taken};
        1:       act = pred_target;
        2:       act = {31'b0, mispredict};
        3:       act = redirect_pc;
        4:       act = stat_branches;
        default: act = stat_mispred;
      endcase
      checks++;
      if (act !== c.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] stat_exp(input int v);
    return STATS ? 32'(v) : 32'h0;
  endfunction

  task automatic push(input string n, input int sel, input logic [31:0] e);
    chk_t c;
    c.name = n; c.sel = sel; c.exp = e;
    sbq.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    upd_valid = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic look(input string n, input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    lookup_pc = pc;
    push({n, ".taken"}, 0, {31'b0, t});
    push({n, ".target"}, 1, tgt);
  endtask

  task automatic stats(input string n);
    push({n, ".branches"}, 4, stat_exp(exp_b));
    push({n, ".mispred"}, 5, stat_exp(exp_m));
  endtask

  task automatic upd(input string n, input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                     input logic pt, input logic [31:0] ptgt, input logic em, input logic [31:0] er,
                     input logic clr);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = t; upd_target = tgt;
    upd_pred_taken = pt; upd_pred_target = ptgt; clear = clr;
    push({n, ".mispredict"}, 2, {31'b0, em});
    if (em) push({n, ".redirect"}, 3, er);
    if (!clr) begin
      exp_b++;
      if (em) exp_m++;
    end
  endtask

  localparam logic [31:0] PA = 32'h0040_0010;
  localparam logic [31:0] PB = 32'h0040_0080;
  localparam logic [31:0] X  = 32'h0040_0800;

  initial begin
    reset = 1'b1; clear = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0; lookup_pc = '0;
    look("rst", PA, 1'b0, 32'h0040_0014);
    stats("rst");
    push("rst.mispredict", 2, 32'h0);
    step(); step();
    reset = 1'b0;

    // Cold miss, taken: allocate weakly-taken; same-cycle lookup sees old state.
    look("cold", PA, 1'b0, 32'h0040_0014);
    upd("u1", PA, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014, 1'b1, 32'h0040_0100, 1'b0);
    step(); idle();
    look("trained", PA, 1'b1, 32'h0040_0100);
    stats("s1");
    upd("u2", PA, 1'b0, 32'h0, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0014, 1'b0);
    step(); idle();
    look("c01", PA, 1'b0, 32'h0040_0014);
    upd("u3", PA, 1'b0, 32'h0, 1'b0, 32'h0040_0014, 1'b0, 32'h0, 1'b0);
    step(); idle();
    look("c00", PA, 1'b0, 32'h0040_0014);
    upd("u4", PA, 1'b0, 32'h0, 1'b0, 32'h0040_0014, 1'b0, 32'h0, 1'b0);
    step(); idle();
    look("sat00", PA, 1'b0, 32'h0040_0014);
    upd("u5", PA, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014, 1'b1, 32'h0040_0100, 1'b0);
    step(); idle();
    look("c01b", PA, 1'b0, 32'h0040_0014);
    upd("u6", PA, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014, 1'b1, 32'h0040_0100, 1'b0);
    step(); idle();
    look("c10", PA, 1'b1, 32'h0040_0100);
    upd("u7", PA, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0100, 1'b0, 32'h0, 1'b0);
    step(); idle();
    upd("u8", PA, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0100, 1'b0, 32'h0, 1'b0);
    step(); idle();
    upd("u9", PA, 1'b0, 32'h0, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0014, 1'b0);
    step(); idle();
    look("sat11", PA, 1'b1, 32'h0040_0100);
    stats("s2");

    // Aliasing: same index, different tag replaces the entry.
    upd("u10", 32'h0040_0050, 1'b1, 32'h0040_0200, 1'b0, 32'h0040_0054, 1'b1, 32'h0040_0200, 1'b0);
    step(); idle();
    look("alias_old", PA, 1'b0, 32'h0040_0014);
    step();
    look("alias_new", 32'h0040_0050, 1'b1, 32'h0040_0200);
    upd("u11", 32'h0040_0050, 1'b1, 32'h0040_0300, 1'b1, 32'h0040_0200, 1'b1, 32'h0040_0300, 1'b0);
    step(); idle();
    look("newtgt_lowbits", 32'h0040_0053, 1'b1, 32'h0040_0300);
    upd("u12", 32'h0040_0020, 1'b0, 32'h0, 1'b0, 32'h0040_0024, 1'b0, 32'h0, 1'b0);
    step(); idle();
    look("noalloc", 32'h0040_0020, 1'b0, 32'h0040_0024);
    stats("s3");
    step();
    look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
    upd("u13", 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0000_0100, 1'b1, 32'h0, 1'b0);
    step(); idle();

    // Clear together with an update: clear wins, update and stats dropped.
    look("clr_same", 32'h0040_0050, 1'b1, 32'h0040_0300);
    upd("uclr", 32'h0040_0020, 1'b1, 32'h0040_0500, 1'b0, 32'h0040_0024, 1'b1, 32'h0040_0500, 1'b1);
    step(); idle();
    look("clr1", 32'h0040_0050, 1'b0, 32'h0040_0054);
    stats("s4");
    step();
    look("clr2", 32'h0040_0020, 1'b0, 32'h0040_0024);
    step();

    // Async reset mid-cycle, then a 10-update / 3-mispredict sequence.
    #2 reset = 1'b1;
    exp_b = 0; exp_m = 0;
    stats("rst2");
    step();
    reset = 1'b0;
    upd("a1", PB, 1'b1, X, 1'b0, 32'h0040_0084, 1'b1, X, 1'b0); step();
    upd("a2", PB, 1'b1, X, 1'b1, X, 1'b0, 32'h0, 1'b0); step();
    upd("a3", PB, 1'b1, X, 1'b1, X, 1'b0, 32'h0, 1'b0); step();
    upd("a4", PB, 1'b1, X, 1'b1, X, 1'b0, 32'h0, 1'b0); step();
    upd("a5", PB, 1'b0, 32'h0, 1'b1, X, 1'b1, 32'h0040_0084, 1'b0); step();
    upd("a6", PB, 1'b1, X, 1'b1, X, 1'b0, 32'h0, 1'b0); step();
    upd("a7", PB, 1'b1, X, 1'b1, X, 1'b0, 32'h0, 1'b0); step();
    upd("a8", PB, 1'b0, 32'h0, 1'b1, X, 1'b1, 32'h0040_0084, 1'b0); step();
    upd("a9", PB, 1'b1, X, 1'b1, X, 1'b0, 32'h0, 1'b0); step();
    upd("a10", PB, 1'b1, X, 1'b1, X, 1'b0, 32'h0, 1'b0); step();
    idle();
    look("seq_trained", PB, 1'b1, X);
    stats("s10");
    step();

    // Reset asserted while an update is being presented.
    upd("a11", PB, 1'b1, 32'h0040_0900, 1'b1, X, 1'b1, 32'h0040_0900, 1'b0);
    #2 reset = 1'b1;
    exp_b = 0; exp_m = 0;
    look("rst_mid", PB, 1'b0, 32'h0040_0084);
    stats("rst_mid");
    step();
    reset = 1'b0;
    idle();
    look("post_rst", PB, 1'b0, 32'h0040_0084);
    stats("post_rst");
    step(); step();

    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
